// File: rtl/spi_wb_sequencer.sv
// Wishbone master that runs one complete SPI transfer through the SPI core's register port:
// DIVIDER, TX0, SS, CTRL.GO, poll until GO clears, read RX0, then deselect SS.
module spi_wb_sequencer #(
  parameter logic [4:0] CTRL_FLAGS  = 5'b00000,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         POLL_LIMIT  = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] tx_dat_in,
  input  logic [6:0]  char_len_in,
  input  logic [15:0] divider_in,
  input  logic [7:0]  ss_in,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rx_dat_o,
  output logic [4:0]  adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic [31:0] dat_in,
  input  logic        ack_in,
  input  logic        err_in
);

  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_TX, WR_SS, WR_GO, RD_POLL, RD_RX, WR_SSCLR, GAP, FINISH
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;              // access to run after the current GAP

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              fail_q, fail_d;
  logic [31:0]       rx_buf_q, rx_buf_d;
  logic [31:0]       tx_q, tx_d;
  logic [6:0]        len_q, len_d;
  logic [15:0]       div_q, div_d;
  logic [7:0]        ss_q, ss_d;

  logic        stb_d;
  logic        we_d;
  logic [4:0]  adr_d;
  logic [31:0] dat_d;

  // Next-state and operand capture.
  // NOTE: every variable gets its default before the case so no path leaves one unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    wait_d   = wait_q;
    poll_d   = poll_q;
    fail_d   = fail_q;
    rx_buf_d = rx_buf_q;
    tx_d     = tx_q;
    len_d    = len_q;
    div_d    = div_q;
    ss_d     = ss_q;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          tx_d    = tx_dat_in;
          len_d   = char_len_in;
          div_d   = divider_in;
          ss_d    = ss_in;
          fail_d  = 1'b0;
          wait_d  = '0;
          poll_d  = '0;
          state_d = WR_DIV;
        end
      end
      GAP:    state_d = ret_q;
      FINISH: state_d = IDLE;
      default: begin
        // Bus access in flight: err_in dominates a simultaneous ack_in.
        if (err_in) begin
          fail_d  = 1'b1;
          wait_d  = '0;
          state_d = FINISH;
        end else if (ack_in) begin
          wait_d  = '0;
          state_d = GAP;
          unique case (state_q)
            WR_DIV: ret_d = WR_TX;
            WR_TX:  ret_d = WR_SS;
            WR_SS:  ret_d = WR_GO;
            WR_GO:  ret_d = RD_POLL;
            RD_POLL: begin
              poll_d = poll_q + POLL_W'(1);
              if (!dat_in[8]) begin
                ret_d = RD_RX;
              end else if (poll_q == POLL_LAST) begin
                fail_d  = 1'b1;
                state_d = FINISH;
              end else begin
                ret_d = RD_POLL;
              end
            end
            RD_RX: begin
              rx_buf_d = dat_in;
              ret_d    = WR_SSCLR;
            end
            default: ret_d = FINISH;
          endcase
        end else if (wait_q == WAIT_LAST) begin
          fail_d  = 1'b1;
          wait_d  = '0;
          state_d = FINISH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    endcase
  end

  // Bus values for the state being entered; registered below so every output is a flop.
  always_comb begin
    stb_d = 1'b0;
    we_d  = 1'b0;
    adr_d = 5'h00;
    dat_d = 32'd0;
    unique case (state_d)
      WR_DIV: begin
        stb_d = 1'b1; we_d = 1'b1; adr_d = ADR_DIV;
        dat_d = {16'd0, div_d};
      end
      WR_TX: begin
        stb_d = 1'b1; we_d = 1'b1; adr_d = ADR_DATA;
        dat_d = tx_d;
      end
      WR_SS: begin
        stb_d = 1'b1; we_d = 1'b1; adr_d = ADR_SS;
        dat_d = {24'd0, ss_d};
      end
      WR_GO: begin
        stb_d = 1'b1; we_d = 1'b1; adr_d = ADR_CTRL;
        dat_d = {18'd0, CTRL_FLAGS, 1'b1, 1'b0, len_d};
      end
      RD_POLL: begin
        stb_d = 1'b1; adr_d = ADR_CTRL;
      end
      RD_RX: begin
        stb_d = 1'b1; adr_d = ADR_DATA;
      end
      WR_SSCLR: begin
        stb_d = 1'b1; we_d = 1'b1; adr_d = ADR_SS;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      wait_q   <= '0;
      poll_q   <= '0;
      fail_q   <= 1'b0;
      rx_buf_q <= 32'd0;
      tx_q     <= 32'd0;
      len_q    <= 7'd0;
      div_q    <= 16'd0;
      ss_q     <= 8'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      rx_dat_o <= 32'd0;
      adr_o    <= 5'h00;
      dat_o    <= 32'd0;
      sel_o    <= 4'h0;
      we_o     <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      wait_q   <= wait_d;
      poll_q   <= poll_d;
      fail_q   <= fail_d;
      rx_buf_q <= rx_buf_d;
      tx_q     <= tx_d;
      len_q    <= len_d;
      div_q    <= div_d;
      ss_q     <= ss_d;
      busy_o   <= (state_d != IDLE);
      done_o   <= (state_d == FINISH);
      err_o    <= (state_d == FINISH) && fail_d;
      if (state_d == FINISH && !fail_d) rx_dat_o <= rx_buf_d;
      adr_o    <= adr_d;
      dat_o    <= dat_d;
      sel_o    <= stb_d ? 4'hF : 4'h0;
      we_o     <= we_d;
      cyc_o    <= stb_d;
      stb_o    <= stb_d;
    end
  end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Scoreboard bench for spi_wb_sequencer: a reference model queues expected bus accesses and
// results per transfer; a behavioural Wishbone slave and a result monitor pop and compare.
module tb_spi_wb_sequencer;

  localparam int ACK_TIMEOUT = 16;
  localparam int POLL_LIMIT  = 1024;

  logic        clk_in, rst_in, start_in;
  logic [31:0] tx_dat_in;
  logic [6:0]  char_len_in;
  logic [15:0] divider_in;
  logic [7:0]  ss_in;
  logic        busy_o, done_o, err_o;
  logic [31:0] rx_dat_o;
  logic [4:0]  adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic [31:0] dat_in;
  logic        ack_in, err_in;

  spi_wb_sequencer #(
    .CTRL_FLAGS(5'b00000), .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .tx_dat_in(tx_dat_in), .char_len_in(char_len_in), .divider_in(divider_in), .ss_in(ss_in),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rx_dat_o(rx_dat_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .dat_in(dat_in), .ack_in(ack_in), .err_in(err_in)
  );

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    logic        err;
    logic [31:0] rx;
    int          lat;
    int          start;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  int cfg_wait = 0, cfg_go_reads = 0, cfg_err_idx = -1, cfg_noack_idx = -1;
  logic [31:0] cfg_rx = 32'd0;
  int acc_idx = 0, poll_seen = 0, last_abandon = 0;
  logic [31:0] model_rx = 32'd0;

  logic        rx_pending = 1'b0;
  logic [31:0] rx_expect  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  function automatic acc_t mk(input logic we, input logic [4:0] adr, input logic [31:0] dat);
    acc_t a;
    a.we = we; a.adr = adr; a.dat = dat;
    return a;
  endfunction

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial forever begin
    @(posedge clk_in);
    cycle_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle_cnt);
    $fatal(1, "watchdog");
  end

  // Behavioural Wishbone slave plus access monitor.
  initial begin : slave
    logic        in_acc, responded, f_we;
    logic [4:0]  f_adr;
    logic [31:0] f_dat;
    int          hold;
    in_acc = 1'b0; responded = 1'b0; hold = 0;
    f_we = 1'b0; f_adr = 5'h0; f_dat = 32'd0;
    ack_in = 1'b0; err_in = 1'b0; dat_in = 32'd0;
    forever begin
      @(negedge clk_in);
      if (stb_o) begin
        if (!in_acc) begin
          in_acc = 1'b1; responded = 1'b0; hold = 0;
          f_adr = adr_o; f_dat = dat_o; f_we = we_o;
        end
        hold++;
        check("adr_stable", {27'd0, adr_o}, {27'd0, f_adr});
        check("dat_stable", dat_o, f_dat);
        check("we_stable", {31'd0, we_o}, {31'd0, f_we});
        check("sel_active", {28'd0, sel_o}, 32'hF);
        check("cyc_eq_stb", {31'd0, cyc_o}, {31'd0, stb_o});
        ack_in = 1'b0; err_in = 1'b0;
        if (acc_idx != cfg_noack_idx && hold > cfg_wait) begin
          if (acc_idx == cfg_err_idx) err_in = 1'b1;
          else ack_in = 1'b1;
          if (!we_o) begin
            if (adr_o == 5'h10) begin
              dat_in = (poll_seen < cfg_go_reads) ? ($urandom | 32'h100) : ($urandom & ~32'h100);
              poll_seen++;
            end else begin
              dat_in = cfg_rx;
            end
          end
          check("access_expected", {31'd0, exp_acc.size() > 0}, 32'd1);
          if (exp_acc.size() > 0) begin
            acc_t e;
            e = exp_acc.pop_front();
            check("acc_we", {31'd0, we_o}, {31'd0, e.we});
            check("acc_adr", {27'd0, adr_o}, {27'd0, e.adr});
            if (e.we) check("acc_dat", dat_o, e.dat);
          end
          acc_idx++;
          responded = 1'b1;
        end
      end else begin
        if (in_acc && !responded) last_abandon = hold;
        in_acc = 1'b0; ack_in = 1'b0; err_in = 1'b0; dat_in = 32'd0;
        check("idle_ctl", {23'd0, cyc_o, we_o, sel_o, adr_o}, 32'd0);
        check("idle_dat", dat_o, 32'd0);
      end
    end
  end

  // Result monitor.
  initial begin : result_mon
    forever begin
      @(negedge clk_in);
      if (done_o) begin
        check("done_expected", {31'd0, exp_res.size() > 0}, 32'd1);
        if (exp_res.size() > 0) begin
          res_t r;
          r = exp_res.pop_front();
          check("err_o", {31'd0, err_o}, {31'd0, r.err});
          check("done_latency", cycle_cnt - r.start, r.lat);
          check("busy_at_done", {31'd0, busy_o}, 32'd1);
          rx_expect  = r.rx;
          rx_pending = 1'b1;
        end
      end else if (rx_pending) begin
        check("rx_dat_o", rx_dat_o, rx_expect);
        check("busy_after_done", {31'd0, busy_o}, 32'd0);
        rx_pending = 1'b0;
      end
    end
  end

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_res.size() != 0 || rx_pending) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("transfer_completes", {31'd0, exp_res.size() == 0 && !rx_pending}, 32'd1);
    @(negedge clk_in);
  endtask

  // Reference model: builds the expected access list, outcome and latency from the transfer rules.
  task automatic run_transfer(input logic [15:0] div, input logic [31:0] tx, input logic [6:0] len,
                              input logic [7:0] ss, input int w, input int go_reads,
                              input logic [31:0] rx, input int err_idx, input int noack_idx,
                              input bit dup_start, input bit no_wait);
    acc_t list[$];
    int   npoll, n, keep, lat;
    logic err;
    bit   lim_err;
    list.push_back(mk(1'b1, 5'h14, {16'd0, div}));
    list.push_back(mk(1'b1, 5'h00, tx));
    list.push_back(mk(1'b1, 5'h18, {24'd0, ss}));
    list.push_back(mk(1'b1, 5'h10, 32'h100 | {25'd0, len}));
    lim_err = (go_reads >= POLL_LIMIT);
    npoll = lim_err ? POLL_LIMIT : go_reads + 1;
    for (int i = 0; i < npoll; i++) list.push_back(mk(1'b0, 5'h10, 32'd0));
    if (!lim_err) begin
      list.push_back(mk(1'b0, 5'h00, 32'd0));
      list.push_back(mk(1'b1, 5'h18, 32'd0));
    end
    n = list.size();
    if (err_idx >= 0 && err_idx < n) begin
      keep = err_idx + 1; err = 1'b1; lat = err_idx * (w + 2) + w + 1;
    end else if (noack_idx >= 0 && noack_idx < n) begin
      keep = noack_idx; err = 1'b1; lat = noack_idx * (w + 2) + ACK_TIMEOUT + 1;
    end else if (lim_err) begin
      keep = n; err = 1'b1; lat = (n - 1) * (w + 2) + w + 1;
    end else begin
      keep = n; err = 1'b0; lat = n * (w + 2);
    end
    if (!err) model_rx = rx;
    for (int i = 0; i < keep; i++) exp_acc.push_back(list[i]);

    cfg_wait = w; cfg_go_reads = go_reads; cfg_rx = rx;
    cfg_err_idx = err_idx; cfg_noack_idx = noack_idx;
    acc_idx = 0; poll_seen = 0;

    @(negedge clk_in);
    start_in = 1'b1; divider_in = div; tx_dat_in = tx; char_len_in = len; ss_in = ss;
    exp_res.push_back('{err: err, rx: model_rx, lat: lat, start: cycle_cnt + 1});
    @(negedge clk_in);
    start_in = 1'b0;
    divider_in = 16'($urandom); tx_dat_in = $urandom; char_len_in = 7'($urandom); ss_in = 8'($urandom);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    if (dup_start) begin
      repeat (3) @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
    end
    if (!no_wait) wait_quiet(lat + 50);
  endtask

  initial begin : main
    rst_in = 1'b1; start_in = 1'b0;
    tx_dat_in = 32'd0; char_len_in = 7'd0; divider_in = 16'd0; ss_in = 8'd0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_rx", rx_dat_o, 32'd0);
    check("rst_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Zero-wait nominal transfer.
    run_transfer(16'h0004, 32'hA5A5_1234, 7'd8, 8'h01, 0, 0, 32'h1357_9BDF, -1, -1, 1'b0, 1'b0);
    // Three busy polls, then RX0 = DEADBEEF.
    run_transfer(16'h0010, 32'h0000_00FF, 7'd16, 8'h02, 0, 3, 32'hDEAD_BEEF, -1, -1, 1'b0, 1'b0);
    // Three wait states on every access.
    run_transfer(16'h0004, 32'hA5A5_1234, 7'd8, 8'h01, 3, 1, 32'hCAFE_F00D, -1, -1, 1'b0, 1'b0);
    // Bus error on the SS write.
    run_transfer(16'h0123, 32'h1111_2222, 7'd32, 8'h04, 0, 0, 32'h7777_7777, 2, -1, 1'b0, 1'b0);
    // Slave never acks the DIVIDER write.
    last_abandon = 0;
    run_transfer(16'h0001, 32'h3333_4444, 7'd1, 8'h08, 0, 0, 32'h5555_5555, -1, 0, 1'b0, 1'b0);
    check("timeout_hold", last_abandon, ACK_TIMEOUT + 1);
    // GO stuck high.
    run_transfer(16'h0002, 32'h6666_7777, 7'd8, 8'h10, 0, 2000, 32'h8888_9999, -1, -1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int go, ei;
      go = $urandom_range(0, 4);
      ei = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6 + go)) : -1;
      run_transfer(16'($urandom), $urandom, 7'($urandom), 8'($urandom),
                   $urandom_range(0, 3), go, $urandom, ei, -1, 1'b0, 1'b0);
    end

    // Reset while polling.
    run_transfer(16'h0004, 32'hABCD_0001, 7'd8, 8'h01, 3, 100, 32'h0BAD_0BAD, -1, -1, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!(poll_seen >= 2 && stb_o && adr_o == 5'h10 && !we_o) && n < 500) begin
        @(negedge clk_in);
        n++;
      end
      check("reach_poll", {31'd0, n < 500}, 32'd1);
    end
    #1;
    exp_acc.delete();
    exp_res.delete();
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_mid_cyc", {31'd0, cyc_o}, 32'd0);
    check("rst_mid_stb", {31'd0, stb_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_done", {31'd0, done_o}, 32'd0);
    rst_in = 1'b0;
    model_rx = 32'd0;
    check("rst_mid_rx", rx_dat_o, 32'd0);
    repeat (4) begin
      @(negedge clk_in);
      check("no_done_after_rst", {31'd0, done_o}, 32'd0);
    end

    // New transfer accepted after reset; a start while busy is ignored.
    run_transfer(16'h0020, 32'h0F0F_F0F0, 7'd12, 8'h80, 0, 1, 32'h2468_ACE0, -1, -1, 1'b1, 1'b0);
    repeat (10) @(negedge clk_in);
    check("no_second_transfer", {31'd0, busy_o}, 32'd0);
    check("acc_queue_empty", exp_acc.size(), 32'd0);
    check("res_queue_empty", exp_res.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
